// File: rtl/key_toggle_gen.sv
// key_toggle_gen
//   Turns a raw, bouncing push-button into a clean one-cycle toggle command
//   for a downstream tff. The key is brought into the clk domain by a
//   two-flop synchroniser, debounced by a counter in both directions, and
//   each accepted press emits one t pulse. With REPEAT_EN set, holding the
//   key emits a first repeat after HOLD_CYCLES and then one every
//   REPEAT_CYCLES. A wrapping counter of emitted pulses drives status LEDs.
//
// Ports
//   clk        clock
//   rst        synchronous reset, active low
//   key_in     raw button level, asynchronous, may bounce
//   en         1: pulses allowed; 0: t and press_cnt held off, FSM still runs
//   t          one-cycle toggle pulse
//   key_stable debounced level, 1 = pressed
//   press_cnt  count of emitted t pulses, wraps modulo 2^PCNT_W
module key_toggle_gen #(
    parameter int unsigned KEY_ACTIVE_LOW = 1,
    parameter int unsigned DEBOUNCE       = 16,
    parameter int unsigned REPEAT_EN      = 0,
    parameter int unsigned HOLD_CYCLES    = 64,
    parameter int unsigned REPEAT_CYCLES  = 16,
    parameter int unsigned CNT_W          = 20,
    parameter int unsigned PCNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_in,
    input  logic              en,
    output logic              t,
    output logic              key_stable,
    output logic [PCNT_W-1:0] press_cnt
);

    // Raw level that means "released"; the synchroniser is reset to it so a
    // key held through reset is seen as a fresh press afterwards.
    localparam logic KEY_REL = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PDEB    = 2'd1,
        PRESSED = 2'd2,
        RDEB    = 2'd3
    } state_t;

    state_t             state;
    logic [1:0]         sync;
    logic               key_s;
    logic [CNT_W-1:0]   cnt;    // press debounce, then hold/repeat count
    logic [CNT_W-1:0]   dcnt;   // release debounce; keeps cnt frozen meanwhile
    logic               rpt;    // hold phase done, cnt now times repeat gaps
    logic [PCNT_W-1:0]  pcnt_inc;

    assign key_s    = (KEY_ACTIVE_LOW != 0) ? ~sync[1] : sync[1];
    assign pcnt_inc = press_cnt + PCNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync <= {2{KEY_REL}};
        end else begin
            sync <= {sync[0], key_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dcnt       <= '0;
            rpt        <= 1'b0;
            t          <= 1'b0;
            key_stable <= 1'b0;
            press_cnt  <= '0;
        end else begin
            t <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_s) begin
                        state <= PDEB;
                        cnt   <= '0;
                    end
                end
                PDEB: begin
                    if (!key_s) begin
                        state <= IDLE;
                    end else if (cnt == DEB_LAST) begin
                        state      <= PRESSED;
                        key_stable <= 1'b1;
                        cnt        <= '0;
                        rpt        <= 1'b0;
                        t          <= en;
                        if (en) press_cnt <= pcnt_inc;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!key_s) begin
                        state <= RDEB;
                        dcnt  <= '0;
                    end else if (REPEAT_EN != 0) begin
                        // First pulse after HOLD_CYCLES, then cnt restarts and
                        // times each REPEAT_CYCLES gap, so it never runs past
                        // the terminal value of the current phase.
                        if ((!rpt && cnt == HOLD_LAST) || (rpt && cnt == REP_LAST)) begin
                            cnt <= '0;
                            rpt <= 1'b1;
                            t   <= en;
                            if (en) press_cnt <= pcnt_inc;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else if (cnt != HOLD_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RDEB: begin
                    // Returning to PRESSED leaves cnt/rpt untouched so the hold
                    // timing resumes where the release bounce interrupted it.
                    if (key_s) begin
                        state <= PRESSED;
                    end else if (dcnt == DEB_LAST) begin
                        state      <= IDLE;
                        key_stable <= 1'b0;
                        cnt        <= '0;
                        rpt        <= 1'b0;
                    end else begin
                        dcnt <= dcnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
